// File: rtl/des_ahb_pkg.sv
// rtl/des_ahb_pkg.sv - shared constants and types for the 3DES AHB FIFO slave
package des_ahb_pkg;

    // Register offsets decoded from HADDR[3:0]
    localparam logic [3:0] ADDR_CTRL   = 4'h0;
    localparam logic [3:0] ADDR_KEY1   = 4'h1;
    localparam logic [3:0] ADDR_KEY2   = 4'h2;
    localparam logic [3:0] ADDR_KEY3   = 4'h3;
    localparam logic [3:0] ADDR_DIN    = 4'h4;
    localparam logic [3:0] ADDR_DOUT   = 4'h8;
    localparam logic [3:0] ADDR_STATUS = 4'h9;

    // CTRL bit positions
    localparam int CTRL_ENCDEC = 0;
    localparam int CTRL_FLUSH  = 2;

    // STATUS bit positions
    localparam int ST_IN_FULL   = 0;
    localparam int ST_IN_EMPTY  = 1;
    localparam int ST_OUT_FULL  = 2;
    localparam int ST_OUT_EMPTY = 3;
    localparam int ST_OVF       = 4;
    localparam int ST_UDF       = 5;
    localparam int ST_KEY_ERR   = 6;
    localparam int ST_IN_CNT    = 8;
    localparam int ST_OUT_CNT   = 16;

    // AHB encodings
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;

    // Address-phase decision carried into the data phase
    typedef struct packed {
        logic       valid;
        logic       write;
        logic [3:0] addr;
        logic       err;
    } dphase_req_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with extra-MSB pointers and flush
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [AW:0]      count_o,
    output logic             full_o,
    output logic             empty_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is allowed only when a pop frees the slot in the same cycle
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    assign count_o = wr_ptr_q - rd_ptr_q;
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer update; flush empties the FIFO without touching storage
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage write
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/des_ahb_fifo_slave.sv
// rtl/des_ahb_fifo_slave.sv - AHB-Lite slave front-end with in/out FIFOs for the 3DES core
module des_ahb_fifo_slave #(
    parameter int IN_DEPTH   = 4,
    parameter int OUT_DEPTH  = 4,
    parameter int OUT_THRESH = 1
) (
    input  logic         HCLK,
    input  logic         HRESET,
    input  logic         HSEL,
    input  logic         HWRITE,
    input  logic         HREADY,
    input  logic [1:0]   HTRANS,
    input  logic [31:0]  HADDR,
    input  logic [2:0]   HSIZE,
    input  logic [63:0]  HWDATA,
    output logic [63:0]  HRDATA,
    output logic         HREADYOUT,
    output logic         HRESP,
    output logic         core_in_valid,
    input  logic         core_in_ready,
    output logic [63:0]  core_in_data,
    output logic         core_encdec,
    output logic [191:0] core_keys,
    input  logic         core_out_valid,
    output logic         core_out_ready,
    input  logic [63:0]  core_out_data,
    output logic         irq
);
    import des_ahb_pkg::*;

    localparam int IAW = $clog2(IN_DEPTH);
    localparam int OAW = $clog2(OUT_DEPTH);

    logic [IAW:0]   in_count;
    logic [OAW:0]   out_count;
    logic           in_full, in_empty, out_full, out_empty;
    logic [63:0]    out_head;
    dphase_req_t    req_q, req_d;
    logic [63:0]    hrdata_q, hrdata_d;
    logic           err2_q;
    logic [63:0]    key1_q, key2_q, key3_q;
    logic           encdec_q;
    logic           ovf_q, udf_q, kerr_q, ovf_d, udf_d, kerr_d;
    logic           accept, busy, pend_push, in_full_lvl, dout_pop, st_clr;
    logic [IAW+1:0] in_level;
    logic           dp_wr, flush, err_now, wr_ok, din_push;
    logic [63:0]    status;
    logic           unused_bits;

    assign unused_bits = ^{HSIZE, HADDR[31:4], HTRANS[0]};

    assign accept      = HSEL & HTRANS[1] & HREADY;
    assign busy        = (in_count != '0) | (core_in_valid & ~core_in_ready);
    // A DIN already in its data phase occupies a slot for the next full check
    assign pend_push   = req_q.valid & req_q.write & ~req_q.err & (req_q.addr == ADDR_DIN);
    assign in_level    = {1'b0, in_count} + {{(IAW + 1){1'b0}}, pend_push};
    assign in_full_lvl = (in_level >= (IAW + 2)'(IN_DEPTH));

    // Data phase: a flush write is never rejected, even when busy at the address phase
    assign dp_wr    = req_q.valid & req_q.write;
    assign flush    = dp_wr & (req_q.addr == ADDR_CTRL) & HWDATA[CTRL_FLUSH];
    assign err_now  = req_q.valid & req_q.err & ~flush;
    assign wr_ok    = dp_wr & ~err_now;
    assign din_push = wr_ok & (req_q.addr == ADDR_DIN);

    // First error cycle stalls the bus, second completes it with HREADYOUT high
    assign HREADYOUT = ~err_now;
    assign HRESP     = (err_now | err2_q) ? HRESP_ERROR : HRESP_OKAY;
    assign HRDATA    = hrdata_q;

    assign core_in_valid  = ~in_empty;
    assign core_out_ready = ~out_full;
    assign core_encdec    = encdec_q;
    assign core_keys      = {key3_q, key2_q, key1_q};
    assign irq            = (32'(out_count) >= 32'(OUT_THRESH)) | ovf_q | udf_q | kerr_q;

    // STATUS word assembled from live FIFO state and sticky flags
    always_comb begin
        status                         = '0;
        status[ST_IN_FULL]             = in_full;
        status[ST_IN_EMPTY]            = in_empty;
        status[ST_OUT_FULL]            = out_full;
        status[ST_OUT_EMPTY]           = out_empty;
        status[ST_OVF]                 = ovf_q;
        status[ST_UDF]                 = udf_q;
        status[ST_KEY_ERR]             = kerr_q;
        status[ST_IN_CNT+:8]           = 8'(in_count);
        status[ST_OUT_CNT+:8]          = 8'(out_count);
    end

    // Address-phase decode: error decision, DOUT pop and read-data capture
    always_comb begin
        req_d    = '0;
        hrdata_d = '0;
        dout_pop = 1'b0;
        st_clr   = 1'b0;
        if (accept) begin
            req_d.valid = 1'b1;
            req_d.write = HWRITE;
            req_d.addr  = HADDR[3:0];
            if (HWRITE) begin
                case (HADDR[3:0])
                    ADDR_DIN:                                  req_d.err = in_full_lvl;
                    ADDR_CTRL, ADDR_KEY1, ADDR_KEY2, ADDR_KEY3: req_d.err = busy;
                    default:                                   req_d.err = 1'b0;
                endcase
            end else begin
                case (HADDR[3:0])
                    ADDR_DOUT: begin
                        if (out_empty) begin
                            req_d.err = 1'b1;
                        end else begin
                            dout_pop = 1'b1;
                            hrdata_d = out_head;
                        end
                    end
                    ADDR_STATUS: begin
                        hrdata_d = status;
                        st_clr   = 1'b1;
                    end
                    default: hrdata_d = '0;
                endcase
            end
        end
    end

    // Sticky flags: a new error beats a same-cycle STATUS clear; flush clears everything
    always_comb begin
        ovf_d  = ovf_q;
        udf_d  = udf_q;
        kerr_d = kerr_q;
        if (st_clr) begin
            ovf_d  = 1'b0;
            udf_d  = 1'b0;
            kerr_d = 1'b0;
        end
        if (err_now & req_q.write & (req_q.addr == ADDR_DIN)) ovf_d  = 1'b1;
        if (err_now & ~req_q.write)                           udf_d  = 1'b1;
        if (err_now & req_q.write & (req_q.addr != ADDR_DIN)) kerr_d = 1'b1;
        if (flush) begin
            ovf_d  = 1'b0;
            udf_d  = 1'b0;
            kerr_d = 1'b0;
        end
    end

    // Bus pipeline, configuration and sticky registers
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            req_q    <= '0;
            hrdata_q <= '0;
            err2_q   <= 1'b0;
            key1_q   <= '0;
            key2_q   <= '0;
            key3_q   <= '0;
            encdec_q <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            kerr_q   <= 1'b0;
        end else begin
            req_q    <= req_d;
            hrdata_q <= hrdata_d;
            err2_q   <= err_now;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            kerr_q   <= kerr_d;
            if (wr_ok) begin
                case (req_q.addr)
                    ADDR_CTRL: encdec_q <= HWDATA[CTRL_ENCDEC];
                    ADDR_KEY1: key1_q   <= HWDATA;
                    ADDR_KEY2: key2_q   <= HWDATA;
                    ADDR_KEY3: key3_q   <= HWDATA;
                    default:   ;
                endcase
            end
        end
    end

    sync_fifo #(.WIDTH(64), .DEPTH(IN_DEPTH)) u_in_fifo (
        .clk_i       (HCLK),
        .rst_i       (HRESET),
        .flush_i     (flush),
        .push_i      (din_push),
        .push_data_i (HWDATA),
        .pop_i       (core_in_ready),
        .head_o      (core_in_data),
        .count_o     (in_count),
        .full_o      (in_full),
        .empty_o     (in_empty)
    );

    sync_fifo #(.WIDTH(64), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk_i       (HCLK),
        .rst_i       (HRESET),
        .flush_i     (flush),
        .push_i      (core_out_valid & core_out_ready),
        .push_data_i (core_out_data),
        .pop_i       (dout_pop),
        .head_o      (out_head),
        .count_o     (out_count),
        .full_o      (out_full),
        .empty_o     (out_empty)
    );

endmodule

// File: tb/tb_des_ahb_fifo_slave.sv
// tb/tb_des_ahb_fifo_slave.sv - randomized self-checking bench for des_ahb_fifo_slave
module tb_des_ahb_fifo_slave;
    localparam int IN_DEPTH   = 4;
    localparam int OUT_DEPTH  = 4;
    localparam int OUT_THRESH = 1;

    logic         clk = 1'b0;
    logic         hreset, hsel, hwrite;
    logic         hready;
    logic [1:0]   htrans;
    logic [31:0]  haddr;
    logic [2:0]   hsize;
    logic [63:0]  hwdata, hrdata;
    logic         hreadyout, hresp;
    logic         core_in_valid, core_in_ready, core_encdec;
    logic [63:0]  core_in_data, core_out_data;
    logic [191:0] core_keys;
    logic         core_out_valid, core_out_ready, irq;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model state
    logic [63:0] m_in[$];
    logic [63:0] m_out[$];
    logic        m_ovf, m_udf, m_kerr, m_mode;
    logic [63:0] m_k1, m_k2, m_k3;

    always #5 clk = ~clk;
    assign hready = hreadyout;

    des_ahb_fifo_slave #(.IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH), .OUT_THRESH(OUT_THRESH)) dut (
        .HCLK(clk), .HRESET(hreset), .HSEL(hsel), .HWRITE(hwrite), .HREADY(hready),
        .HTRANS(htrans), .HADDR(haddr), .HSIZE(hsize), .HWDATA(hwdata), .HRDATA(hrdata),
        .HREADYOUT(hreadyout), .HRESP(hresp),
        .core_in_valid(core_in_valid), .core_in_ready(core_in_ready), .core_in_data(core_in_data),
        .core_encdec(core_encdec), .core_keys(core_keys),
        .core_out_valid(core_out_valid), .core_out_ready(core_out_ready),
        .core_out_data(core_out_data), .irq(irq)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    function automatic logic [63:0] exp_status();
        logic [63:0] s = '0;
        s[0]     = (m_in.size() == IN_DEPTH);
        s[1]     = (m_in.size() == 0);
        s[2]     = (m_out.size() == OUT_DEPTH);
        s[3]     = (m_out.size() == 0);
        s[4]     = m_ovf;
        s[5]     = m_udf;
        s[6]     = m_kerr;
        s[15:8]  = 8'(m_in.size());
        s[23:16] = 8'(m_out.size());
        return s;
    endfunction

    task automatic model_reset();
        m_in.delete(); m_out.delete();
        m_ovf = 0; m_udf = 0; m_kerr = 0; m_mode = 0;
        m_k1 = '0; m_k2 = '0; m_k3 = '0;
    endtask

    // One non-overlapped AHB transfer with response and read-data checks
    task automatic xfer(input bit wr, input logic [3:0] a, input logic [63:0] wd,
                        input bit exp_err, input logic [63:0] exp_rd, input string tag);
        @(negedge clk);
        hsel = 1; htrans = 2'b10; hwrite = wr; haddr = {28'($urandom()), a};
        hsize = 3'($urandom()); hwdata = rnd64();
        @(negedge clk);
        hsel = 0; htrans = 2'b00; hwdata = wd;
        #1;
        if (!exp_err) begin
            check({tag, "_okay"}, {hreadyout, hresp}, 2'b10);
            if (!wr) check({tag, "_rdata"}, hrdata, exp_rd);
        end else begin
            check({tag, "_err1"}, {hreadyout, hresp}, 2'b01);
            if (!wr) check({tag, "_errdata"}, hrdata, 64'h0);
            @(negedge clk); #1;
            check({tag, "_err2"}, {hreadyout, hresp}, 2'b11);
        end
    endtask

    task automatic check_state();
        @(negedge clk);
        check("irq", irq, (m_out.size() >= OUT_THRESH) || m_ovf || m_udf || m_kerr);
        check("in_valid", core_in_valid, m_in.size() != 0);
        if (m_in.size() != 0) check("in_data", core_in_data, m_in[0]);
        check("out_ready", core_out_ready, m_out.size() < OUT_DEPTH);
        check("encdec", core_encdec, m_mode);
        check("key1", core_keys[63:0], m_k1);
        check("key2", core_keys[127:64], m_k2);
        check("key3", core_keys[191:128], m_k3);
    endtask

    task automatic op_din(input logic [63:0] d);
        bit e = (m_in.size() == IN_DEPTH);
        xfer(1, 4'h4, d, e, '0, "din");
        if (e) m_ovf = 1; else m_in.push_back(d);
    endtask

    task automatic op_dout();
        bit e = (m_out.size() == 0);
        logic [63:0] r = e ? 64'h0 : m_out[0];
        xfer(0, 4'h8, '0, e, r, "dout");
        if (e) m_udf = 1; else void'(m_out.pop_front());
    endtask

    task automatic op_status();
        xfer(0, 4'h9, '0, 0, exp_status(), "status");
        m_ovf = 0; m_udf = 0; m_kerr = 0;
    endtask

    task automatic op_key(input int k, input logic [63:0] d);
        bit e = (m_in.size() != 0);
        xfer(1, 4'(k), d, e, '0, "key");
        if (e) m_kerr = 1;
        else if (k == 1) m_k1 = d;
        else if (k == 2) m_k2 = d;
        else m_k3 = d;
    endtask

    task automatic op_ctrl(input logic [63:0] d);
        bit fl = d[2];
        bit e = (m_in.size() != 0) && !fl;
        xfer(1, 4'h0, d, e, '0, "ctrl");
        if (e) m_kerr = 1;
        else begin
            m_mode = d[0];
            if (fl) begin
                m_in.delete(); m_out.delete();
                m_ovf = 0; m_udf = 0; m_kerr = 0;
            end
        end
    endtask

    task automatic op_other();
        bit wr = 1'($urandom());
        logic [3:0] a = $urandom_range(0, 1) ? 4'(5 + $urandom_range(0, 2)) : 4'(10 + $urandom_range(0, 5));
        xfer(wr, a, rnd64(), 0, 64'h0, "other");
    endtask

    task automatic core_pop();
        @(negedge clk);
        check("pop_valid", core_in_valid, m_in.size() != 0);
        if (m_in.size() != 0) check("pop_data", core_in_data, m_in[0]);
        core_in_ready = 1;
        @(negedge clk);
        core_in_ready = 0;
        if (m_in.size() != 0) void'(m_in.pop_front());
    endtask

    task automatic core_push(input logic [63:0] d);
        @(negedge clk);
        check("push_ready", core_out_ready, m_out.size() < OUT_DEPTH);
        core_out_valid = 1; core_out_data = d;
        @(negedge clk);
        core_out_valid = 0;
        if (m_out.size() < OUT_DEPTH) m_out.push_back(d);
    endtask

    // Pipelined DIN writes that run the input FIFO exactly one past full
    task automatic din_burst();
        int n = IN_DEPTH - m_in.size() + 1;
        logic [63:0] v;
        @(negedge clk);
        hsel = 1; htrans = 2'b10; hwrite = 1; haddr = 32'h4;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            v = rnd64(); hwdata = v;
            if (i == n - 1) begin hsel = 0; htrans = 2'b00; end
            #1;
            if (m_in.size() < IN_DEPTH) begin
                check("burst_okay", {hreadyout, hresp}, 2'b10);
                m_in.push_back(v);
            end else begin
                check("burst_err1", {hreadyout, hresp}, 2'b01);
                @(negedge clk); #1;
                check("burst_err2", {hreadyout, hresp}, 2'b11);
                m_ovf = 1;
            end
        end
    endtask

    initial begin
        hreset = 1; hsel = 0; hwrite = 0; htrans = 2'b00; haddr = '0; hsize = 3'b011;
        hwdata = '0; core_in_ready = 0; core_out_valid = 0; core_out_data = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_hrdata", hrdata, 64'h0);
        check("rst_resp", {hreadyout, hresp}, 2'b10);
        check("rst_in_valid", core_in_valid, 0);
        check("rst_out_ready", core_out_ready, 1);
        check("rst_irq", irq, 0);
        check("rst_keys", core_keys[63:0] | core_keys[127:64] | core_keys[191:128], 64'h0);
        hreset = 0;

        // Configure and push one block
        op_ctrl(64'h1); check_state();
        op_key(1, {16{4'h1}}); op_key(2, {16{4'h2}}); op_key(3, {16{4'h3}}); check_state();
        op_din({16{4'h5}}); check_state();
        op_status();
        core_pop(); check_state();

        // Overflow on the fifth DIN with the core stalled
        for (int i = 0; i < 5; i++) op_din(rnd64());
        check_state();
        op_status(); check_state();

        // Underflow and sticky clear on read
        op_ctrl(64'h5); check_state();
        op_dout(); check_state();
        op_status(); op_status(); check_state();

        // Core results read back in order
        core_push({16{4'hA}}); core_push({16{4'hB}}); check_state();
        op_dout(); check_state();
        op_dout(); check_state();

        // Key write while busy, then flush
        op_din(rnd64()); op_din(rnd64());
        op_key(2, rnd64()); check_state();
        op_ctrl(64'h5); check_state();
        op_status();

        // Back-to-back streaming into the input FIFO
        din_burst(); check_state();
        op_status(); check_state();

        // Randomized operation mix
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 8))
                0, 1: op_din(rnd64());
                2:    op_dout();
                3:    op_status();
                4:    op_key($urandom_range(1, 3), rnd64());
                5: begin
                    logic [63:0] d = rnd64();
                    if (d[2]) d[0] = m_mode;
                    op_ctrl(d);
                end
                6:    op_other();
                7:    core_pop();
                default: core_push(rnd64());
            endcase
            check_state();
        end

        // Reset during the first ERROR cycle cancels the response
        op_ctrl({63'h0, m_mode} | 64'h4);
        for (int i = 0; i < IN_DEPTH; i++) op_din(rnd64());
        core_push(rnd64());
        @(negedge clk);
        hsel = 1; htrans = 2'b10; hwrite = 1; haddr = 32'h4;
        @(negedge clk);
        hsel = 0; htrans = 2'b00; hwdata = rnd64(); hreset = 1;
        #1;
        check("rst_mid_err1", {hreadyout, hresp}, 2'b01);
        @(negedge clk); #1;
        check("rst_mid_resp", {hreadyout, hresp}, 2'b10);
        check("rst_mid_in_valid", core_in_valid, 0);
        hreset = 0;
        model_reset();
        check_state();
        op_status();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
